// File: rtl/rvc_asap_pkg.sv
// Shared types and defaults for the RVC ASAP core and its boot-time helpers.
package rvc_asap_pkg;

  localparam int unsigned I_MEM_MSB  = 1023;
  localparam logic [7:0]  LOAD_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_MAGIC = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } t_loader_state;

endpackage

// File: rtl/rvc_asap_word_packer.sv
// Packs a little-endian byte stream into 32-bit words, first byte landing in [7:0].
module rvc_asap_word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  // The 4th byte is not stored; the word is presented combinationally on its acceptance.
  assign word_o      = {data_i, shift_q};
  assign word_done_o = valid_i && (idx_q == 2'd3);

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (valid_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {data_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/rvc_asap_imem_loader.sv
// Boot loader: parses a framed byte stream into I_MEM word writes and holds the core until done.
module rvc_asap_imem_loader #(
  parameter int unsigned I_MEM_MSB  = rvc_asap_pkg::I_MEM_MSB,
  parameter logic [7:0]  LOAD_MAGIC = rvc_asap_pkg::LOAD_MAGIC
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  input  logic        Reload,
  output logic        IMemWrEn,
  output logic [31:0] IMemWrAddr,
  output logic [31:0] IMemWrData,
  output logic        CoreHold,
  output logic        LoadDone,
  output logic        LoadErr,
  output logic [15:0] WordCnt
);
  import rvc_asap_pkg::*;

  localparam logic [31:0] Capacity = 32'(I_MEM_MSB) + 32'd1;

  t_loader_state state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ready_en_q;

  logic        accept, reload_ok, pack_valid, word_done, too_big;
  logic [15:0] len_full;
  logic [17:0] len_bytes;
  logic [31:0] word;

  // ready_en_q keeps InReady low while reset is held and until the first edge after release.
  assign InReady    = ready_en_q && !(state_q inside {S_DONE, S_ERR});
  assign accept     = InValid && InReady;
  assign reload_ok  = Reload && (state_q inside {S_DONE, S_ERR});
  assign pack_valid = accept && (state_q == S_DATA);
  assign len_full   = {InData, len_q[7:0]};
  assign len_bytes  = {len_full, 2'b00};
  assign too_big    = {14'd0, len_bytes} > Capacity;

  assign IMemWrEn   = wr_en_q;
  assign IMemWrAddr = wr_addr_q;
  assign IMemWrData = wr_data_q;
  assign WordCnt    = word_cnt_q;
  assign CoreHold   = (state_q != S_DONE);
  assign LoadDone   = (state_q == S_DONE);
  assign LoadErr    = (state_q == S_ERR);

  rvc_asap_word_packer u_packer (
    .clk_i       (Clock),
    .rst_ni      (Rst),
    .clear_i     (reload_ok),
    .valid_i     (pack_valid),
    .data_i      (InData),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      S_MAGIC: if (accept && InData == LOAD_MAGIC) state_d = S_LEN0;
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = InData;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) state_d = S_CSUM;
          else if (too_big)      state_d = S_ERR;
          else                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (pack_valid) begin
          csum_d = csum_q ^ InData;
          if (word_done) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = {14'd0, word_cnt_q, 2'b00};
            wr_data_d  = word;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_d == len_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: if (accept) state_d = (InData == csum_q) ? S_DONE : S_ERR;
      S_DONE, S_ERR: begin
        if (Reload) begin
          state_d    = S_MAGIC;
          word_cnt_d = 16'd0;
          csum_d     = 8'd0;
        end
      end
      default: state_d = S_MAGIC;
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_MAGIC;
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      csum_q     <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rvc_asap_imem_loader.sv
// Scoreboard bench for the I_MEM loader: a frame-level model predicts writes and final status.
module tb_rvc_asap_imem_loader;

  localparam int unsigned MSB   = 1023;
  localparam logic [7:0]  MAGIC = 8'hA5;

  logic        Clock = 1'b0;
  logic        Rst = 1'b0;
  logic        InValid = 1'b0;
  logic [7:0]  InData = 8'd0;
  logic        Reload = 1'b0;
  logic        InReady, IMemWrEn, CoreHold, LoadDone, LoadErr;
  logic [31:0] IMemWrAddr, IMemWrData;
  logic [15:0] WordCnt;

  always #5 Clock = ~Clock;

  rvc_asap_imem_loader #(
    .I_MEM_MSB  (MSB),
    .LOAD_MAGIC (MAGIC)
  ) dut (
    .Clock      (Clock),
    .Rst        (Rst),
    .InValid    (InValid),
    .InData     (InData),
    .InReady    (InReady),
    .Reload     (Reload),
    .IMemWrEn   (IMemWrEn),
    .IMemWrAddr (IMemWrAddr),
    .IMemWrData (IMemWrData),
    .CoreHold   (CoreHold),
    .LoadDone   (LoadDone),
    .LoadErr    (LoadErr),
    .WordCnt    (WordCnt)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  frame[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          gap_mode = 0;   // 0: back-to-back, 1: idle every other cycle, 2: random idles
  logic        prev_en = 1'b0;
  logic        exp_done, exp_err;
  logic [15:0] exp_words;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Monitor: every write strobe must match the oldest predicted write and be one cycle wide.
  always @(negedge Clock) begin
    if (Rst) begin
      if (IMemWrEn) begin
        chk("wren_width", 32'(prev_en), 32'd0);
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", IMemWrAddr, e.addr);
          chk("wr_data", IMemWrData, e.data);
        end
      end
      prev_en <= IMemWrEn;
    end else begin
      prev_en <= 1'b0;
    end
  end

  // Reference model: interpret the whole frame by its rules, predicting writes and final status.
  task automatic model();
    int i = 0;
    int n;
    logic [7:0] x = 8'd0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 16'd0;
    while (i < frame.size() && frame[i] != MAGIC) i++;
    n = int'(frame[i+1]) + 256 * int'(frame[i+2]);
    i += 3;
    if (4 * n > MSB + 1) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      wr_t e;
      e.addr = 32'(4 * w);
      e.data = {frame[i+3], frame[i+2], frame[i+1], frame[i]};
      x = x ^ frame[i] ^ frame[i+1] ^ frame[i+2] ^ frame[i+3];
      exp_q.push_back(e);
      i += 4;
    end
    exp_words = 16'(n);
    if (frame[i] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic build(input int n, input bit bad, input int garbage);
    logic [7:0]  b;
    logic [7:0]  x = 8'd0;
    logic [15:0] nn;
    nn = 16'(n);
    frame.delete();
    repeat (garbage) begin
      b = 8'($urandom_range(0, 255));
      frame.push_back((b == MAGIC) ? 8'h00 : b);
    end
    frame.push_back(MAGIC);
    frame.push_back(nn[7:0]);
    frame.push_back(nn[15:8]);
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom_range(0, 255));
      frame.push_back(b);
      x = x ^ b;
    end
    frame.push_back(bad ? ~x : x);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int t = 0;
    if (gap_mode == 1) begin
      InValid = 1'b0;
      @(posedge Clock); #1;
    end else if (gap_mode == 2) begin
      repeat ($urandom_range(0, 2)) begin
        InValid = 1'b0;
        Reload  = 1'($urandom_range(0, 1));
        @(posedge Clock); #1;
      end
    end
    Reload  = 1'b0;
    InValid = 1'b1;
    InData  = b;
    do begin
      @(negedge Clock);
      ok = InReady;
      @(posedge Clock); #1;
      t++;
    end while (!ok && t < 50);
    InValid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame();
    foreach (frame[k]) send_byte(frame[k]);
  endtask

  task automatic end_checks(input string tag);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk({tag, "_load_done"}, 32'(LoadDone), 32'(exp_done));
    chk({tag, "_load_err"}, 32'(LoadErr), 32'(exp_err));
    chk({tag, "_core_hold"}, 32'(CoreHold), 32'(!exp_done));
    chk({tag, "_in_ready"}, 32'(InReady), 32'd0);
    chk({tag, "_word_cnt"}, 32'(WordCnt), 32'(exp_words));
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Reload with a concurrent MAGIC byte offered; that byte must not be taken.
  task automatic do_reload(input string tag);
    @(posedge Clock); #1;
    Reload  = 1'b1;
    InValid = 1'b1;
    InData  = MAGIC;
    @(posedge Clock); #1;
    Reload  = 1'b0;
    InValid = 1'b0;
    chk({tag, "_reload_ready"}, 32'(InReady), 32'd1);
    chk({tag, "_reload_wcnt"}, 32'(WordCnt), 32'd0);
    chk({tag, "_reload_hold"}, 32'(CoreHold), 32'd1);
  endtask

  task automatic run(input string tag);
    model();
    send_frame();
    end_checks(tag);
    do_reload(tag);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rst_ready"}, 32'(InReady), 32'd0);
    chk({tag, "_rst_hold"}, 32'(CoreHold), 32'd1);
    chk({tag, "_rst_wren"}, 32'(IMemWrEn), 32'd0);
    chk({tag, "_rst_addr"}, IMemWrAddr, 32'd0);
    chk({tag, "_rst_data"}, IMemWrData, 32'd0);
    chk({tag, "_rst_done"}, 32'(LoadDone), 32'd0);
    chk({tag, "_rst_err"}, 32'(LoadErr), 32'd0);
    chk({tag, "_rst_wcnt"}, 32'(WordCnt), 32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge Clock);
    Rst = 1'b1;
    #1 chk({tag, "_ready_pre_edge"}, 32'(InReady), 32'd0);
    @(posedge Clock); #1;
    chk({tag, "_ready_post_edge"}, 32'(InReady), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    #3 reset_checks("init");
    repeat (2) @(posedge Clock);
    release_reset("init");

    // Two-word program; checksum byte is the XOR of the payload (0x90).
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run("two_word");

    frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
    run("garbage_lead");

    build(1, 1'b1, 0);
    run("bad_csum");

    frame = '{MAGIC, 8'h00, 8'h80};
    run("len_8000");

    frame = '{MAGIC, 8'h01, 8'h01};
    run("len_257");

    build(0, 1'b0, 0);
    run("len_zero");

    build(256, 1'b0, 0);
    run("len_full");

    // Reset in the middle of the first word: nothing may be written.
    frame = '{MAGIC, 8'h01, 8'h00, 8'h11, 8'h22};
    send_frame();
    #2 Rst = 1'b0;
    #1 reset_checks("midrst_async");
    @(posedge Clock);
    @(negedge Clock);
    reset_checks("midrst_held");
    release_reset("midrst");
    build(2, 1'b0, 0);
    run("after_rst");

    gap_mode = 1;
    build(3, 1'b0, 0);
    run("toggle_valid");

    gap_mode = 2;
    for (int r = 0; r < 6; r++) begin
      build($urandom_range(1, 8), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      run($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
